adder_pipe: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with carry-in, carry-out, signed overflow and valid/ready flow control. The operands are split into STAGES equal slices. Each pipeline stage adds one slice and registers its carry into the next stage. It is the general-purpose wide adder for the multiplier partial-product reduction and final accumulation paths. It replaces fixed-width combinational ripple adders on timing-critical paths.

---
 rtl/adder_pipe_if.sv | 26 ++
 rtl/adder_pipe.sv | 97 +++++++++
 tb/tb_adder_pipe.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_pipe_if.sv
// rtl/adder_pipe_if.sv - operand/result handshake bundle for adder_pipe
interface adder_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - sliced, pipelined add/sub with carry chain registered per slice
module adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic        clk,
    input  logic        rst,
    adder_pipe_if.slave io
);
    localparam int W = WIDTH / STAGES;

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign adv         = !io.out_valid || io.out_ready;
    assign io.in_ready = adv;
    assign b_eff       = io.sub ? ~io.b : io.b;
    assign c0          = io.cin ^ io.sub;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        // HI = operand bits not yet consumed when this stage starts
        localparam int HI = WIDTH - k * W;

        logic [HI-1:0]      op_a;
        logic [HI-1:0]      op_b;
        logic               ci;
        logic               vi;
        logic [W:0]         slice;
        logic [(k+1)*W-1:0] sum_d;
        logic [(k+1)*W-1:0] sum_q;
        logic               c_q;
        logic               v_q;

        assign slice = {1'b0, op_a[W-1:0]} + {1'b0, op_b[W-1:0]} + {{W{1'b0}}, ci};

        if (k == 0) begin : g_src
            assign op_a  = io.a;
            assign op_b  = b_eff;
            assign ci    = c0;
            assign vi    = io.in_valid;
            assign sum_d = slice[W-1:0];
        end else begin : g_src
            assign op_a  = stg[k-1].g_skew.a_q;
            assign op_b  = stg[k-1].g_skew.b_q;
            assign ci    = stg[k-1].c_q;
            assign vi    = stg[k-1].v_q;
            assign sum_d = {slice[W-1:0], stg[k-1].sum_q};
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q <= '0;
                c_q   <= 1'b0;
                v_q   <= 1'b0;
            end else if (adv) begin
                sum_q <= sum_d;
                c_q   <= slice[W];
                v_q   <= vi;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            // upper operand slices ride along until their stage comes up
            logic [HI-W-1:0] a_q;
            logic [HI-W-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= op_a[HI-1:W];
                    b_q <= op_b[HI-1:W];
                end
            end
        end else begin : g_top
            logic ovf_q;
            logic c_msb;

            assign c_msb = op_a[W-1] ^ op_b[W-1] ^ slice[W-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= c_msb ^ slice[W];
                end
            end
        end
    end

    assign io.out_valid = stg[STAGES-1].v_q;
    assign io.sum       = stg[STAGES-1].sum_q;
    assign io.cout      = stg[STAGES-1].c_q;
    assign io.ovf       = stg[STAGES-1].g_top.ovf_q;
endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - three adder_pipe configurations against an arithmetic reference model
module tb_adder_pipe;
    localparam int ND   = 3;
    localparam int MAXS = 4;
    localparam int NOPS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv[ND];
    logic [31:0] ia[ND];
    logic [31:0] ib[ND];
    logic        ic[ND];
    logic        is_sub[ND];
    logic        ordy;

    adder_pipe_if #(.WIDTH(32)) if0 ();
    adder_pipe_if #(.WIDTH(32)) if1 ();
    adder_pipe_if #(.WIDTH(12)) if2 ();

    adder_pipe #(.WIDTH(32), .STAGES(4)) dut0 (.clk(clk), .rst(rst), .io(if0));
    adder_pipe #(.WIDTH(32), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .io(if1));
    adder_pipe #(.WIDTH(12), .STAGES(3)) dut2 (.clk(clk), .rst(rst), .io(if2));

    assign if0.in_valid = iv[0];
    assign if0.a = ia[0];
    assign if0.b = ib[0];
    assign if0.cin = ic[0];
    assign if0.sub = is_sub[0];
    assign if0.out_ready = ordy;
    assign if1.in_valid = iv[1];
    assign if1.a = ia[1];
    assign if1.b = ib[1];
    assign if1.cin = ic[1];
    assign if1.sub = is_sub[1];
    assign if1.out_ready = ordy;
    assign if2.in_valid = iv[2];
    assign if2.a = ia[2][11:0];
    assign if2.b = ib[2][11:0];
    assign if2.cin = ic[2];
    assign if2.sub = is_sub[2];
    assign if2.out_ready = ordy;

    logic        obs_v[ND];
    logic        obs_r[ND];
    logic [33:0] obs_x[ND];

    always_comb begin
        obs_v[0] = if0.out_valid;
        obs_r[0] = if0.in_ready;
        obs_x[0] = {if0.ovf, if0.cout, if0.sum};
        obs_v[1] = if1.out_valid;
        obs_r[1] = if1.in_ready;
        obs_x[1] = {if1.ovf, if1.cout, if1.sum};
        obs_v[2] = if2.out_valid;
        obs_r[2] = if2.in_ready;
        obs_x[2] = {if2.ovf, if2.cout, 20'd0, if2.sum};
    end

    // reference: slot j of mv/mx is the beat that will emerge after the remaining stages
    logic        mv[ND][MAXS];
    logic [33:0] mx[ND][MAXS];
    logic [33:0] lastx[ND];
    logic        acc[ND];
    int          n_out[ND];
    int          n_checks = 0;
    int          n_pass = 0;

    logic [31:0] la[NOPS];
    logic [31:0] lb[NOPS];
    logic        lc[NOPS];
    logic        ls[NOPS];
    int          ptr[ND];
    int          base[ND];
    int          first[ND];
    logic        held[ND];
    logic [33:0] hx[ND];
    int          cyc;

    function automatic int stg_of(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int wid_of(input int d);
        return (d == 2) ? 12 : 32;
    endfunction

    function automatic logic [33:0] ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                           input logic ci, input logic s);
        longint mask, ma, mb, c, full, lim, sa, sb, st;
        logic   ov;
        logic   cy;
        mask = (longint'(1) << w) - 1;
        ma   = {32'd0, a} & mask;
        mb   = {32'd0, (s ? ~b : b)} & mask;
        c    = (ci ^ s) ? 1 : 0;
        full = ma + mb + c;
        lim  = longint'(1) << (w - 1);
        sa   = (ma >= lim) ? ma - (lim << 1) : ma;
        sb   = (mb >= lim) ? mb - (lim << 1) : mb;
        st   = sa + sb + c;
        ov   = (st >= lim) || (st < -lim);
        cy   = full[w];
        return {ov, cy, 32'(full & mask)};
    endfunction

    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic reset_model();
        for (int d = 0; d < ND; d++) begin
            for (int j = 0; j < MAXS; j++) begin
                mv[d][j] = 1'b0;
                mx[d][j] = '0;
            end
        end
    endtask

    task automatic step();
        logic adv;
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            int s = stg_of(d);
            adv    = !mv[d][s-1] || ordy;
            acc[d] = adv && iv[d];
            if (adv) begin
                if (mv[d][s-1]) n_out[d]++;
                for (int j = s - 1; j > 0; j--) begin
                    mv[d][j] = mv[d][j-1];
                    mx[d][j] = mx[d][j-1];
                end
                mv[d][0] = iv[d];
                mx[d][0] = ref_op(wid_of(d), ia[d], ib[d], ic[d], is_sub[d]);
            end
        end
        #1;
        for (int d = 0; d < ND; d++) begin
            int s = stg_of(d);
            check($sformatf("out_valid[%0d]", d), 34'(obs_v[d]), 34'(mv[d][s-1]));
            check($sformatf("in_ready[%0d]", d), 34'(obs_r[d]), 34'(!mv[d][s-1] || ordy));
            if (mv[d][s-1]) begin
                check($sformatf("result[%0d]", d), obs_x[d], mx[d][s-1]);
                lastx[d] = obs_x[d];
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drive_all(input logic v, input logic [31:0] a, input logic [31:0] b,
                             input logic c, input logic s);
        for (int d = 0; d < ND; d++) begin
            iv[d]     = v;
            ia[d]     = a;
            ib[d]     = b;
            ic[d]     = c;
            is_sub[d] = s;
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
        drive_all(1'b1, a, b, c, s);
        step();
        for (int d = 0; d < ND; d++) iv[d] = 1'b0;
    endtask

    task automatic dir(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s, input logic [33:0] exp);
        for (int d = 0; d < ND; d++) lastx[d] = 'x;
        issue(a, b, c, s);
        idle(4);
        check({tag, "_st4"}, lastx[0], exp);
        check({tag, "_st1"}, lastx[1], exp);
    endtask

    function automatic logic stream_done();
        for (int d = 0; d < ND; d++) begin
            if (ptr[d] < NOPS) return 1'b0;
            for (int j = 0; j < MAXS; j++) if (mv[d][j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ordy = 1'b1;
        drive_all(1'b0, '0, '0, 1'b0, 1'b0);
        reset_model();
        for (int d = 0; d < ND; d++) n_out[d] = 0;

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("reset_valid[%0d]", d), 34'(obs_v[d]), 34'd0);
            check($sformatf("reset_data[%0d]", d), obs_x[d], 34'd0);
            check($sformatf("reset_ready[%0d]", d), 34'(obs_r[d]), 34'd1);
        end
        rst = 1'b0;
        idle(2);

        dir("slice_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0000_0100});
        dir("ripple_b1",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
        dir("ripple_cin",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
        dir("ovf_pos",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
        dir("ovf_neg",     32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, {1'b1, 1'b1, 32'h0000_0000});
        dir("sub_borrow",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
        dir("sub_cin",     32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0001});

        // back-to-back stream with out_ready dropped for cycles 5..7
        for (int i = 0; i < NOPS; i++) begin
            la[i] = $urandom;
            lb[i] = $urandom;
            lc[i] = 1'($urandom_range(0, 1));
            ls[i] = 1'($urandom_range(0, 1));
        end
        for (int d = 0; d < ND; d++) begin
            ptr[d]  = 0;
            base[d] = n_out[d];
        end
        cyc = 0;
        while (cyc < 80 && !stream_done()) begin
            ordy = !(cyc >= 5 && cyc <= 7);
            for (int d = 0; d < ND; d++) begin
                iv[d] = (ptr[d] < NOPS);
                if (ptr[d] < NOPS) begin
                    ia[d]     = la[ptr[d]];
                    ib[d]     = lb[ptr[d]];
                    ic[d]     = lc[ptr[d]];
                    is_sub[d] = ls[ptr[d]];
                end
            end
            #1;
            for (int d = 0; d < ND; d++) begin
                check($sformatf("ready_vs_stall[%0d]", d), 34'(obs_r[d]), 34'(!(obs_v[d] && !ordy)));
                held[d] = obs_v[d] && !ordy;
                hx[d]   = obs_x[d];
            end
            step();
            for (int d = 0; d < ND; d++) begin
                if (held[d]) begin
                    check($sformatf("stall_valid[%0d]", d), 34'(obs_v[d]), 34'd1);
                    check($sformatf("stall_data[%0d]", d), obs_x[d], hx[d]);
                end
                if (acc[d]) ptr[d]++;
            end
            cyc++;
        end
        ordy = 1'b1;
        for (int d = 0; d < ND; d++) iv[d] = 1'b0;
        check("stream_bound", 34'(cyc < 80), 34'd1);
        for (int d = 0; d < ND; d++)
            check($sformatf("stream_count[%0d]", d), 34'(n_out[d] - base[d]), 34'(NOPS));

        // three beats in flight, then an asynchronous reset pulse between clock edges
        for (int i = 0; i < 3; i++) begin
            drive_all(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
        end
        for (int d = 0; d < ND; d++) iv[d] = 1'b0;
        rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("async_valid[%0d]", d), 34'(obs_v[d]), 34'd0);
            check($sformatf("async_data[%0d]", d), obs_x[d], 34'd0);
            check($sformatf("async_ready[%0d]", d), 34'(obs_r[d]), 34'd1);
        end
        reset_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);

        issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int d = 0; d < ND; d++) first[d] = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) step();
            for (int d = 0; d < ND; d++) if (first[d] == 0 && obs_v[d]) first[d] = k;
        end
        for (int d = 0; d < ND; d++)
            check($sformatf("post_reset_latency[%0d]", d), 34'(first[d]), 34'(stg_of(d)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
